// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core constants and types for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  // x0 never creates a dependency, and unused source fields are ignored.
  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input sb_entry_t entry);
    return used && (rs != 5'd0) && entry.valid && (entry.rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Load scoreboard: shift register of in-flight load destinations with two
// parallel lookup ports for the decode-stage source registers.
module load_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       push_valid,
  input  logic [4:0] push_rd,
  input  logic       lookup_used_a,
  input  logic [4:0] lookup_rs_a,
  input  logic       lookup_used_b,
  input  logic [4:0] lookup_rs_b,
  output logic       hit_a,
  output logic       hit_b
);

  sb_entry_t        entry_reg [DEPTH];
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK) begin
        if (clear) begin
          entry_reg[gi] <= '0;
        end else if (shift_en) begin
          if (gi == 0) begin
            entry_reg[gi].valid <= push_valid;
            entry_reg[gi].rd    <= push_rd;
          end else begin
            entry_reg[gi] <= entry_reg[gi-1];
          end
        end
      end

      assign match_a[gi] = src_match(lookup_used_a, lookup_rs_a, entry_reg[gi]);
      assign match_b[gi] = src_match(lookup_used_b, lookup_rs_b, entry_reg[gi]);
    end
  endgenerate

  assign hit_a = |match_a;
  assign hit_b = |match_b;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory freeze and taken-branch
// flush/redirect sequencing.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_load,
  input  logic        ex_branch_taken,
  input  logic [63:0] ex_branch_target,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        id_hold,
  output logic        ex_bubble,
  output logic        if_flush,
  output logic        id_flush,
  output logic        pc_redirect,
  output logic [63:0] pc_target,
  output logic [31:0] stall_cnt
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  hz_state_e  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic       redirect_reg, redirect_next;
  logic [63:0] pc_target_reg;
  logic [31:0] stall_cnt_reg;

  logic hit_rs1, hit_rs2;
  logic hazard, in_idle, issue, load_use_stall, branch_accept;

  assign in_idle        = (state_reg == ST_IDLE);
  assign hazard         = id_valid & (hit_rs1 | hit_rs2);
  assign issue          = id_valid & ~hazard & ~mem_busy & ~ex_branch_taken & in_idle;
  assign load_use_stall = hazard & ~ex_branch_taken & in_idle & ~mem_busy;
  assign branch_accept  = in_idle & ex_branch_taken & ~mem_busy;

  load_scoreboard #(
    .DEPTH(LOAD_LAT)
  ) u_scoreboard (
    .CLK          (CLK),
    .clear        (reset),
    .shift_en     (~mem_busy),
    .push_valid   (issue & id_load & (id_rd != 5'd0)),
    .push_rd      (id_rd),
    .lookup_used_a(id_rs1_used),
    .lookup_rs_a  (id_rs1),
    .lookup_used_b(id_rs2_used),
    .lookup_rs_b  (id_rs2),
    .hit_a        (hit_rs1),
    .hit_b        (hit_rs2)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    redirect_next = redirect_reg;
    case (state_reg)
      ST_IDLE: begin
        if (branch_accept) begin
          state_next    = ST_FLUSH;
          cnt_next      = CNT_W'(FLUSH_CYCLES);
          redirect_next = 1'b1;
        end
      end
      ST_FLUSH: begin
        // The redirect pulse is consumed by the first flush cycle even if frozen.
        redirect_next = 1'b0;
        if (!mem_busy) begin
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      redirect_reg  <= 1'b0;
      pc_target_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      redirect_reg <= redirect_next;
      if (branch_accept) begin
        pc_target_reg <= ex_branch_target;
      end
      if (load_use_stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  // Control outputs are forced low for the whole reset window.
  always_comb begin
    pc_stall    = 1'b0;
    id_hold     = 1'b0;
    ex_bubble   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    pc_redirect = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pc_stall = 1'b1;
        id_hold  = 1'b1;
      end else if (load_use_stall) begin
        pc_stall  = 1'b1;
        id_hold   = 1'b1;
        ex_bubble = 1'b1;
      end
      if (!in_idle) begin
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        pc_redirect = redirect_reg;
      end
    end
  end

  assign pc_target = pc_target_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

  logic        CLK;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_load;
  logic        ex_branch_taken;
  logic [63:0] ex_branch_target;
  logic        mem_busy;
  logic        pc_stall, id_hold, ex_bubble, if_flush, id_flush, pc_redirect;
  logic [63:0] pc_target;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall = 32'd0;

  pipe_hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(2)) dut (
    .CLK(CLK), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_load(id_load),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .mem_busy(mem_busy), .pc_stall(pc_stall), .id_hold(id_hold),
    .ex_bubble(ex_bubble), .if_flush(if_flush), .id_flush(id_flush),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_load = 0; ex_branch_taken = 0; ex_branch_target = '0; mem_busy = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    idle_inputs();
    id_valid = 1; id_load = 1; id_rd = rd;
  endtask

  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    idle_inputs();
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = 1; id_rs2_used = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; mem_busy = 1;
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL reset_pc_stall got %b exp 0", pc_stall); end
    step(); step();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0h exp 0", stall_cnt); end
    checks++; if (pc_target !== 64'd0) begin errors++; $display("FAIL reset_pc_target got %0h exp 0", pc_target); end
    reset = 0; mem_busy = 0;
    #1;
    checks++; if ({pc_stall, id_hold, ex_bubble, if_flush, id_flush, pc_redirect} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 000000", {pc_stall, id_hold, ex_bubble, if_flush, id_flush, pc_redirect});
    end
    $display("[reset] outputs=%b stall_cnt=%0d", {pc_stall, id_hold, ex_bubble, if_flush, id_flush, pc_redirect}, stall_cnt);
  endtask

  task automatic test_load_x0();
    drive_load(5'd0);
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL x0_load_stall got %b exp 0", pc_stall); end
    step();
    drive_add(5'd6, 5'd0, 5'd0);
    #1;
    checks++; if (pc_stall !== 1'b0 || ex_bubble !== 1'b0) begin
      errors++; $display("FAIL x0_add_stall got %b%b exp 00", pc_stall, ex_bubble);
    end
    step();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL x0_stall_cnt got %0d exp 0", stall_cnt); end
    $display("[load_x0] stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_load_use();
    drive_load(5'd5);
    #1;
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL lu_load_issue got %b exp 0", pc_stall); end
    step();
    drive_add(5'd6, 5'd5, 5'd7);
    #1;
    checks++; if ({pc_stall, id_hold, ex_bubble} !== 3'b111) begin
      errors++; $display("FAIL lu_stall1 got %b exp 111", {pc_stall, id_hold, ex_bubble});
    end
    step();
    checks++; if ({pc_stall, id_hold, ex_bubble} !== 3'b111) begin
      errors++; $display("FAIL lu_stall2 got %b exp 111", {pc_stall, id_hold, ex_bubble});
    end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt1 got %0d exp 1", stall_cnt); end
    step();
    checks++; if ({pc_stall, id_hold, ex_bubble} !== 3'b000) begin
      errors++; $display("FAIL lu_issue got %b exp 000", {pc_stall, id_hold, ex_bubble});
    end
    exp_stall = 32'd2;
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL lu_cnt2 got %0d exp %0d", stall_cnt, exp_stall); end
    step();
    idle_inputs();
    $display("[load_use] stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_branch();
    idle_inputs();
    step(); step();
    ex_branch_taken = 1; ex_branch_target = 64'h8000_0040;
    #1;
    checks++; if (if_flush !== 1'b0 || pc_redirect !== 1'b0) begin
      errors++; $display("FAIL br_same_cycle got %b%b exp 00", if_flush, pc_redirect);
    end
    step();
    idle_inputs();
    #1;
    checks++; if ({pc_redirect, if_flush, id_flush} !== 3'b111) begin
      errors++; $display("FAIL br_f1 got %b exp 111", {pc_redirect, if_flush, id_flush});
    end
    checks++; if (pc_target !== 64'h8000_0040) begin errors++; $display("FAIL br_target got %0h exp 80000040", pc_target); end
    step();
    // wrong-path branch during the flush must be ignored
    ex_branch_taken = 1; ex_branch_target = 64'hDEAD_0000;
    #1;
    checks++; if ({pc_redirect, if_flush, id_flush} !== 3'b011) begin
      errors++; $display("FAIL br_f2 got %b exp 011", {pc_redirect, if_flush, id_flush});
    end
    step();
    idle_inputs();
    #1;
    checks++; if ({pc_redirect, if_flush, id_flush} !== 3'b000) begin
      errors++; $display("FAIL br_idle got %b exp 000", {pc_redirect, if_flush, id_flush});
    end
    checks++; if (pc_target !== 64'h8000_0040) begin errors++; $display("FAIL br_wrongpath_target got %0h exp 80000040", pc_target); end
    $display("[branch] pc_target=%0h", pc_target);
  endtask

  task automatic test_branch_hazard();
    drive_load(5'd5);
    step();
    drive_add(5'd6, 5'd5, 5'd7);
    ex_branch_taken = 1; ex_branch_target = 64'h0000_1000;
    #1;
    checks++; if (ex_bubble !== 1'b0 || pc_stall !== 1'b0) begin
      errors++; $display("FAIL bh_bubble got %b%b exp 00", ex_bubble, pc_stall);
    end
    step();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL bh_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
    checks++; if (if_flush !== 1'b1 || pc_redirect !== 1'b1) begin
      errors++; $display("FAIL bh_flush got %b%b exp 11", if_flush, pc_redirect);
    end
    checks++; if (pc_target !== 64'h0000_1000) begin errors++; $display("FAIL bh_target got %0h exp 1000", pc_target); end
    step(); step();
    $display("[branch_hazard] stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_mem_busy();
    int flushes = 0;
    int pulses  = 0;
    // mem_busy overrides a live load-use hazard
    drive_load(5'd5);
    step();
    drive_add(5'd6, 5'd5, 5'd7);
    mem_busy = 1;
    #1;
    checks++; if ({pc_stall, id_hold, ex_bubble} !== 3'b110) begin
      errors++; $display("FAIL mb_dominates got %b exp 110", {pc_stall, id_hold, ex_bubble});
    end
    step();
    mem_busy = 0;
    #1;
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL mb_no_count got %0d exp %0d", stall_cnt, exp_stall); end
    checks++; if (ex_bubble !== 1'b1) begin errors++; $display("FAIL mb_held_sb got %b exp 1", ex_bubble); end
    step(); step();
    exp_stall = exp_stall + 32'd2;
    idle_inputs();
    ex_branch_taken = 1; ex_branch_target = 64'h0000_2000;
    step();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      mem_busy = (i < 3);
      #1;
      if (if_flush) flushes++;
      if (pc_redirect) pulses++;
      step();
    end
    idle_inputs();
    checks++; if (flushes != 5) begin errors++; $display("FAIL mb_flush_len got %0d exp 5", flushes); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL mb_redirect_pulses got %0d exp 1", pulses); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL mb_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
    $display("[mem_busy] flush_cycles=%0d redirects=%0d stall_cnt=%0d", flushes, pulses, stall_cnt);
  endtask

  task automatic test_reset_in_flush();
    drive_load(5'd5);
    step();
    idle_inputs();
    ex_branch_taken = 1; ex_branch_target = 64'h0000_3000;
    step();
    idle_inputs();
    reset = 1;
    #1;
    checks++; if ({pc_stall, id_hold, ex_bubble, if_flush, id_flush, pc_redirect} !== 6'b0) begin
      errors++; $display("FAIL rf_outputs got %b exp 000000", {pc_stall, id_hold, ex_bubble, if_flush, id_flush, pc_redirect});
    end
    step();
    reset = 0;
    drive_add(5'd6, 5'd5, 5'd7);
    #1;
    checks++; if ({pc_stall, ex_bubble, if_flush, pc_redirect} !== 4'b0) begin
      errors++; $display("FAIL rf_issue got %b exp 0000", {pc_stall, ex_bubble, if_flush, pc_redirect});
    end
    checks++; if (pc_target !== 64'd0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL rf_regs got %0h/%0d exp 0/0", pc_target, stall_cnt);
    end
    // reset directly behind a load must also clear the scoreboard
    step();
    drive_load(5'd5);
    step();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    drive_add(5'd6, 5'd5, 5'd7);
    #1;
    checks++; if (pc_stall !== 1'b0 || ex_bubble !== 1'b0) begin
      errors++; $display("FAIL rf_sb_clear got %b%b exp 00", pc_stall, ex_bubble);
    end
    step();
    idle_inputs();
    $display("[reset_in_flush] pc_target=%0h stall_cnt=%0d", pc_target, stall_cnt);
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_x0();
    test_load_use();
    test_branch();
    test_branch_hazard();
    test_mem_busy();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
